rf_sequencer: RTL and testbench
===============================

RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 FUN_DEC, 3'b000, FunSel code for register decrement.
REQ-002 FUN_INC, 3'b001, FunSel code for register increment.
REQ-003 FUN_LOAD, 3'b010, FunSel code for register load from I.
REQ-004 FUN_CLEAR, 3'b011, FunSel code for register clear.
REQ-005 ALU_PASSA, 4'b0000, AluFunSel code that passes ALU input A to the result unchanged.
REQ-006 Clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 Reset  in  1  reset is synchronous and active-low.
REQ-008 Instr  in  16  instruction: Op[15:13], Dst[12:10], SrcA[9:7], SrcB[6:4], AluCode[3:0], LDI immediate = Instr[9:0].
REQ-009 InstrValid  in  1  Instr is valid.
REQ-010 InstrReady  out  1  sequencer can accept; transfer occurs on an edge where InstrValid and InstrReady are both high.
REQ-011 OutASel, OutBSel  out  3  register file read selects; index 0-3 = R1-R4, 4-7 = S1-S4.
REQ-012 FunSel  out  3  register file function code.
REQ-013 RegSel, ScrSel  out  4  active-low write enables; bit 3 = R1/S1, bit 0 = R4/S4; 4'b1111 = no write.
REQ-014 AluFunSel  out  4  ALU operation code.
REQ-015 IMuxSel  out  1  register file I source: 0 = ALU result, 1 = Imm.
REQ-016 Imm  out  16  {6'b0, IR[9:0]}.
REQ-017 Busy  out  1  high in every non-IDLE state.
REQ-018 Done  out  1  one-cycle pulse, registered, after the final write of an instruction.
REQ-019 Error  out  1  one-cycle pulse, registered, on a rejected instruction.

Function
REQ-020 States IDLE, EXEC1, EXEC2, EXEC3; InstrReady SHALL equal (state == IDLE).
REQ-021 On acceptance, Instr SHALL be latched into internal register IR and state SHALL go to EXEC1; outputs SHALL be decoded from state and IR only.
REQ-022 Write enable for index d: d<4 clears RegSel[3-d]; d>=4 clears ScrSel[7-d]; all other bits stay 1; at most one enable bit is low per cycle.
REQ-023 Outside EXEC states: RegSel = ScrSel = 4'b1111, OutASel = OutBSel = 0, AluFunSel = ALU_PASSA, IMuxSel = 0, FunSel = FUN_LOAD.
REQ-024 Op 000 NOP: EXEC1 with no write enabled.
REQ-025 Op 001 LDI: EXEC1: IMuxSel = 1, FunSel = FUN_LOAD, enable Dst.
REQ-026 Op 010 MOV: EXEC1: OutASel = SrcA, AluFunSel = ALU_PASSA, IMuxSel = 0, FunSel = FUN_LOAD, enable Dst.
REQ-027 Op 011 ALU: EXEC1: OutASel = SrcA, OutBSel = SrcB, AluFunSel = AluCode, IMuxSel = 0, FunSel = FUN_LOAD, enable Dst.
REQ-028 Op 100 INC / 101 DEC / 110 CLR: EXEC1: FunSel = FUN_INC / FUN_DEC / FUN_CLEAR, enable Dst.
REQ-029 Op 111 SWAP (temp S4): EXEC1 S4 <- Dst (OutASel = Dst, pass-A, load); EXEC2 Dst <- SrcA; EXEC3 SrcA <- S4 (OutASel = 7).
REQ-030 SWAP with Dst = 7 or SrcA = 7: EXEC1 SHALL enable no write, then return to IDLE with Error and Done pulsed together.
REQ-031 SWAP with Dst = SrcA (both < 7): SHALL execute all three steps normally.
REQ-032 Single-step ops: EXEC1 -> IDLE; SWAP: EXEC1 -> EXEC2 -> EXEC3 -> IDLE.
REQ-033 Timing: accept at edge E0; first write at E1; Done high in the cycle after the last write edge.
REQ-034 InstrReady SHALL be high in the Done cycle, allowing a back-to-back accept with no bubble.
REQ-035 Instr and InstrValid SHALL be ignored while Busy.

Reset
REQ-036 With Reset low at a rising edge, the block SHALL set state = IDLE, IR = 0, Done = 0 and Error = 0.
REQ-037 While Reset is low, RegSel and ScrSel SHALL be forced to 4'b1111 combinationally, even mid-SWAP.
REQ-038 Reset mid-operation SHALL abandon the instruction with no further writes and no Done.
REQ-039 InstrReady SHALL be 0 while Reset is low and 1 in the first cycle after release.

Verification
REQ-040 Reset release -> InstrReady = 1, Busy = 0, RegSel = ScrSel = 4'b1111, Done = 0.
REQ-041 LDI Dst = 2, imm 10'h155 -> next cycle: IMuxSel = 1, Imm = 16'h0155, FunSel = 3'b010, RegSel = 4'b1101; following cycle Done = 1.
REQ-042 ALU Dst = 5, SrcA = 0, SrcB = 3, AluCode = 4'b0110 -> OutASel = 0, OutBSel = 3, AluFunSel = 4'b0110, ScrSel = 4'b1011, RegSel = 4'b1111.
REQ-043 SWAP Dst = 1, SrcA = 4 -> three cycles with ScrSel = 4'b1110, then RegSel = 4'b1011, then ScrSel = 4'b0111 (OutASel = 1, 4, 7 respectively); Done in the 4th cycle; with the register file attached, R2 = 16'hAAAA and S1 = 16'h5555 are exchanged.
REQ-044 SWAP Dst = 7 -> no enable low in any cycle; Error = Done = 1 for one cycle.
REQ-045 Reset asserted during EXEC2 of a SWAP -> enables 4'b1111 in that cycle, IDLE next cycle, no Done; INC Dst = 0 issued back-to-back in a Done cycle -> accepted with zero bubble.

Source files
------------

// File: rtl/rf_sequencer.sv
// rf_sequencer: instruction sequencer driving a register file / ALU datapath.
// Accepts one 16-bit instruction at a time through a valid/ready handshake,
// latches it into IR and steps through one to three EXEC states. Each state
// decodes the datapath controls from state and IR only.
//
// Ports
//   Clock, Reset           : rising-edge clock; synchronous active-low reset
//   Instr, InstrValid      : instruction input and its valid strobe
//   InstrReady             : high when idle and not in reset
//   OutASel, OutBSel       : register file read selects (0-3 R1-R4, 4-7 S1-S4)
//   FunSel                 : register file function code
//   RegSel, ScrSel         : active-low write enables (bit 3 = R1/S1)
//   AluFunSel              : ALU operation code
//   IMuxSel                : register file input source (0 ALU, 1 Imm)
//   Imm                    : zero-extended IR[9:0]
//   Busy, Done, Error      : status; Done/Error are registered one-cycle pulses
module rf_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Instr,
    input  logic        InstrValid,
    output logic        InstrReady,
    output logic [2:0]  OutASel,
    output logic [2:0]  OutBSel,
    output logic [2:0]  FunSel,
    output logic [3:0]  RegSel,
    output logic [3:0]  ScrSel,
    output logic [3:0]  AluFunSel,
    output logic        IMuxSel,
    output logic [15:0] Imm,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;
    localparam logic [3:0] ALU_PASSA = 4'b0000;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_ALU  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    // S4 doubles as the SWAP temporary
    localparam logic [2:0] IDX_S4 = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC1 = 2'd1,
        S_EXEC2 = 2'd2,
        S_EXEC3 = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [2:0]  op, dst, src_a, src_b;
    logic [3:0]  alu_code;
    logic        swap_bad;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [7:0]  en_n;

    assign op       = ir_q[15:13];
    assign dst      = ir_q[12:10];
    assign src_a    = ir_q[9:7];
    assign src_b    = ir_q[6:4];
    assign alu_code = ir_q[3:0];
    // SWAP touching S4 would clobber its own temporary: reject it
    assign swap_bad = (dst == IDX_S4) || (src_a == IDX_S4);

    // Next state, IR capture and status pulses
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (InstrValid) begin
                    ir_d    = Instr;
                    state_d = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (op == OP_SWAP && !swap_bad) begin
                    state_d = S_EXEC2;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = (op == OP_SWAP);
                end
            end
            S_EXEC2: state_d = S_EXEC3;
            S_EXEC3: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath control decode from state and IR
    always_comb begin
        OutASel   = 3'd0;
        OutBSel   = 3'd0;
        FunSel    = FUN_LOAD;
        AluFunSel = ALU_PASSA;
        IMuxSel   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = dst;
        case (state_q)
            S_EXEC1: begin
                case (op)
                    OP_NOP: wr_en = 1'b0;
                    OP_LDI: begin
                        IMuxSel = 1'b1;
                        wr_en   = 1'b1;
                    end
                    OP_MOV: begin
                        OutASel = src_a;
                        wr_en   = 1'b1;
                    end
                    OP_ALU: begin
                        OutASel   = src_a;
                        OutBSel   = src_b;
                        AluFunSel = alu_code;
                        wr_en     = 1'b1;
                    end
                    OP_INC: begin
                        FunSel = FUN_INC;
                        wr_en  = 1'b1;
                    end
                    OP_DEC: begin
                        FunSel = FUN_DEC;
                        wr_en  = 1'b1;
                    end
                    OP_CLR: begin
                        FunSel = FUN_CLEAR;
                        wr_en  = 1'b1;
                    end
                    OP_SWAP: begin
                        // S4 <- Dst
                        OutASel = dst;
                        wr_idx  = IDX_S4;
                        wr_en   = !swap_bad;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            S_EXEC2: begin
                // Dst <- SrcA
                OutASel = src_a;
                wr_idx  = dst;
                wr_en   = 1'b1;
            end
            S_EXEC3: begin
                // SrcA <- S4
                OutASel = IDX_S4;
                wr_idx  = src_a;
                wr_en   = 1'b1;
            end
            default: wr_en = 1'b0;
        endcase
    end

    // {RegSel, ScrSel} form one 8-bit active-low vector where index d maps
    // to bit 7-d; gating with Reset blocks writes combinationally in reset.
    always_comb begin
        en_n = 8'hFF;
        if (wr_en && Reset) begin
            en_n[3'd7 - wr_idx] = 1'b0;
        end
    end

    assign RegSel     = en_n[7:4];
    assign ScrSel     = en_n[3:0];
    assign Imm        = {6'b0, ir_q[9:0]};
    assign InstrReady = Reset && (state_q == S_IDLE);
    assign Busy       = (state_q != S_IDLE);
    assign Done       = done_q;
    assign Error      = error_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Testbench for rf_sequencer: scoreboard of expected per-cycle controls and
// Done/Error pulses, plus an attached register file checked against an
// architectural register model.
module tb_rf_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Instr = 16'h0000;
    logic        InstrValid = 1'b0;
    logic        InstrReady;
    logic [2:0]  OutASel, OutBSel, FunSel;
    logic [3:0]  RegSel, ScrSel, AluFunSel;
    logic        IMuxSel;
    logic [15:0] Imm;
    logic        Busy, Done, Error;

    rf_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Instr(Instr), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .OutASel(OutASel), .OutBSel(OutBSel),
        .FunSel(FunSel), .RegSel(RegSel), .ScrSel(ScrSel),
        .AluFunSel(AluFunSel), .IMuxSel(IMuxSel), .Imm(Imm),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]  outa, outb, fun;
        logic [3:0]  alu;
        logic        imux;
        logic [7:0]  en;
        logic [15:0] imm;
        bit          full;
    } exp_t;

    exp_t exec_q[$];
    bit   done_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    logic [15:0] init_v[8];
    logic [15:0] rf[8];
    logic [15:0] mdl[8];
    logic        rf_loaded = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    // Environment ALU: only pass-A is defined for the sequencer; other codes
    // just need to be some deterministic function shared with the model.
    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        return (c == 4'b0000) ? a : ((a ^ b) + {12'b0, c});
    endfunction

    // Active-low enable vector for register index d ({RegSel,ScrSel} order)
    function automatic logic [7:0] wen(input logic [2:0] d);
        return ~(8'h80 >> d);
    endfunction

    always @(posedge Clock) cyc++;

    // Register file attached to the sequencer outputs
    always @(posedge Clock) begin : regfile
        logic [15:0] i_v;
        logic [7:0]  en;
        if (!rf_loaded) begin
            for (int d = 0; d < 8; d++) rf[d] <= init_v[d];
            rf_loaded <= 1'b1;
        end else begin
            i_v = IMuxSel ? Imm : alu_f(AluFunSel, rf[OutASel], rf[OutBSel]);
            en  = {RegSel, ScrSel};
            for (int d = 0; d < 8; d++) begin
                if (!en[7-d]) begin
                    case (FunSel)
                        3'b000:  rf[d] <= rf[d] - 16'd1;
                        3'b001:  rf[d] <= rf[d] + 16'd1;
                        3'b010:  rf[d] <= i_v;
                        3'b011:  rf[d] <= 16'h0000;
                        default: rf[d] <= rf[d];
                    endcase
                end
            end
        end
    end

    // Reference model: per-cycle expected controls and architectural effect
    task automatic model_accept(input logic [15:0] ins);
        logic [2:0]  op, dst, sa, sb;
        logic [3:0]  ac;
        logic [15:0] t;
        exp_t e;
        op = ins[15:13]; dst = ins[12:10]; sa = ins[9:7]; sb = ins[6:4]; ac = ins[3:0];
        e.outa = 3'd0; e.outb = 3'd0; e.fun = 3'b010; e.alu = 4'b0000;
        e.imux = 1'b0; e.en = 8'hFF; e.imm = {6'b0, ins[9:0]}; e.full = 1'b1;
        if (op == 3'b111) begin
            if (dst == 3'd7 || sa == 3'd7) begin
                e.full = 1'b0;
                exec_q.push_back(e);
                done_q.push_back(1'b1);
            end else begin
                e.outa = dst; e.en = wen(3'd7); exec_q.push_back(e);
                e.outa = sa;  e.en = wen(dst);  exec_q.push_back(e);
                e.outa = 3'd7; e.en = wen(sa);  exec_q.push_back(e);
                done_q.push_back(1'b0);
                t = mdl[dst];
                mdl[dst] = mdl[sa];
                mdl[sa]  = t;
                mdl[7]   = t;
            end
            return;
        end
        if (op != 3'b000) e.en = wen(dst);
        case (op)
            3'b001: begin e.imux = 1'b1; mdl[dst] = {6'b0, ins[9:0]}; end
            3'b010: begin e.outa = sa; mdl[dst] = mdl[sa]; end
            3'b011: begin
                e.outa = sa; e.outb = sb; e.alu = ac;
                mdl[dst] = alu_f(ac, mdl[sa], mdl[sb]);
            end
            3'b100: begin e.fun = 3'b001; mdl[dst] = mdl[dst] + 16'd1; end
            3'b101: begin e.fun = 3'b000; mdl[dst] = mdl[dst] - 16'd1; end
            3'b110: begin e.fun = 3'b011; mdl[dst] = 16'h0000; end
            default: ;
        endcase
        exec_q.push_back(e);
        done_q.push_back(1'b0);
    endtask

    // Monitor: compares whatever the DUT presents each cycle
    always @(negedge Clock) begin
        exp_t e;
        bit   er;
        if (!Reset) begin
            chk("rst_en", {RegSel, ScrSel}, 8'hFF);
            chk("rst_ready", InstrReady, 1'b0);
        end else begin
            if (Busy) begin
                if (exec_q.size() == 0) begin
                    fail_now("exec_extra");
                end else begin
                    e = exec_q.pop_front();
                    chk("en", {RegSel, ScrSel}, e.en);
                    chk("imm", Imm, e.imm);
                    chk("busy_ready", InstrReady, 1'b0);
                    if (e.full) begin
                        chk("outa", OutASel, e.outa);
                        chk("outb", OutBSel, e.outb);
                        chk("funsel", FunSel, e.fun);
                        chk("alufun", AluFunSel, e.alu);
                        chk("imux", IMuxSel, e.imux);
                    end
                end
            end else begin
                chk("idle_en", {RegSel, ScrSel}, 8'hFF);
                chk("idle_ready", InstrReady, 1'b1);
                chk("idle_ctrl", {OutASel, OutBSel, FunSel, AluFunSel, IMuxSel},
                    {3'd0, 3'd0, 3'b010, 4'b0000, 1'b0});
            end
            if (Done) begin
                if (done_q.size() == 0) begin
                    fail_now("done_extra");
                end else begin
                    er = done_q.pop_front();
                    chk("error", Error, er);
                end
            end else if (Error) begin
                fail_now("error_without_done");
            end
        end
    end

    // Present one instruction and hold it until accepted
    task automatic issue(input logic [15:0] ins);
        int waited;
        waited = 0;
        Instr = ins;
        InstrValid = 1'b1;
        @(negedge Clock);
        while (!InstrReady) begin
            waited++;
            if (waited > 20) begin
                fail_now("accept_timeout");
                InstrValid = 1'b0;
                return;
            end
            @(negedge Clock);
        end
        model_accept(ins);
        acc_cyc = cyc;
        @(posedge Clock);
        #1;
        InstrValid = 1'b0;
        Instr = 16'($urandom);
    endtask

    initial begin
        logic [15:0] mdl_save[8];
        int          prev;
        int          budget;
        for (int d = 0; d < 8; d++) init_v[d] = 16'($urandom);
        init_v[1] = 16'hAAAA;
        init_v[4] = 16'h5555;
        for (int d = 0; d < 8; d++) mdl[d] = init_v[d];

        // Reset and release
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        chk("rel_ready", InstrReady, 1'b1);
        chk("rel_busy", Busy, 1'b0);
        chk("rel_en", {RegSel, ScrSel}, 8'hFF);
        chk("rel_done", Done, 1'b0);
        @(posedge Clock); #1;

        // LDI R3 <- 0x155
        issue({3'b001, 3'd2, 10'h155});
        @(negedge Clock);
        chk("ldi_imm", Imm, 16'h0155);
        chk("ldi_regsel", RegSel, 4'b1101);
        chk("ldi_imux", IMuxSel, 1'b1);
        chk("ldi_fun", FunSel, 3'b010);
        @(negedge Clock);
        chk("ldi_done", Done, 1'b1);
        @(posedge Clock); #1;

        // ALU S2 <- R1 op R4
        issue({3'b011, 3'd5, 3'd0, 3'd3, 4'b0110});
        @(negedge Clock);
        chk("alu_scrsel", ScrSel, 4'b1011);
        chk("alu_regsel", RegSel, 4'b1111);
        chk("alu_sel", {OutASel, OutBSel, AluFunSel}, {3'd0, 3'd3, 4'b0110});
        @(posedge Clock); #1;

        // SWAP R2 <-> S1 with register file attached
        issue({3'b111, 3'd1, 3'd4, 7'd0});
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        chk("swap_r2", rf[1], 16'h5555);
        chk("swap_s1", rf[4], 16'hAAAA);
        @(posedge Clock); #1;

        // Rejected SWAP touching S4
        issue({3'b111, 3'd7, 3'd2, 7'd0});
        repeat (3) @(posedge Clock); #1;

        // Reset during EXEC2 of a SWAP: only the EXEC1 write lands
        for (int d = 0; d < 8; d++) mdl_save[d] = mdl[d];
        issue({3'b111, 3'd3, 3'd0, 7'd0});
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_mid_en", {RegSel, ScrSel}, 8'hFF);
        @(posedge Clock); #1;
        Reset = 1'b1;
        exec_q.delete();
        done_q.delete();
        for (int d = 0; d < 8; d++) mdl[d] = mdl_save[d];
        mdl[7] = mdl_save[3];
        repeat (3) begin
            @(negedge Clock);
            chk("rst_no_done", {Done, Busy}, 2'b00);
        end
        @(posedge Clock); #1;

        // Back-to-back accept in the Done cycle
        issue({3'b110, 3'd6, 10'd0});
        prev = acc_cyc;
        issue({3'b100, 3'd0, 10'd0});
        chk("b2b_gap", acc_cyc - prev, 2);

        // Randomized traffic with random idle gaps
        for (int n = 0; n < 200; n++) begin
            issue(16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            #1;
        end

        budget = 0;
        while ((exec_q.size() != 0 || done_q.size() != 0) && budget < 50) begin
            @(posedge Clock);
            budget++;
        end
        if (budget >= 50) fail_now("drain_timeout");
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        for (int d = 0; d < 8; d++) chk($sformatf("reg%0d", d), rf[d], mdl[d]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
